// File: rtl/pc_unit.sv
// Program counter with an optional circular return-address stack (RAS).
// Define PC_UNIT_RAS_EN to compile in the RAS; otherwise selPC=11 selects Bus.
module pc_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = 16'h3000,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ldPC,
    input  logic [1:0]       selPC,
    input  logic             push,
    input  logic [WIDTH-1:0] eabOut,
    input  logic [WIDTH-1:0] Bus,
    output logic [WIDTH-1:0] PCOut,
    output logic [WIDTH-1:0] pcInc,
    output logic [4:0]       rasCount,
    output logic             rasErr
);

    logic [WIDTH-1:0] pc_nxt;

    assign pcInc = PCOut + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) PCOut <= RESET_VEC;
        else       PCOut <= pc_nxt;
    end

`ifdef PC_UNIT_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top_ptr, ptr_nxt, ptr_up, ptr_dn, wr_ptr;
    logic [4:0]       cnt_nxt;
    logic             err_nxt, wr_en, empty;

    assign empty = (rasCount == 5'd0);

    // Pointer wrap is explicit so non-power-of-two depths stay circular.
    always_comb begin
        ptr_up = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + PW'(1);
        ptr_dn = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - PW'(1);
    end

    always_comb begin
        pc_nxt  = PCOut;
        cnt_nxt = rasCount;
        ptr_nxt = top_ptr;
        wr_en   = 1'b0;
        wr_ptr  = top_ptr;
        err_nxt = 1'b0;
        if (ldPC) begin
            case (selPC)
                2'b00:   pc_nxt = pcInc;
                2'b01:   pc_nxt = eabOut;
                2'b10:   pc_nxt = Bus;
                default: begin
                    if (!empty) pc_nxt = ras_mem[top_ptr];
                    else        err_nxt = 1'b1;
                end
            endcase
            if (selPC == 2'b11) begin
                if (!empty) begin
                    // Push during pop replaces the top in place.
                    if (push) begin
                        wr_en  = 1'b1;
                        wr_ptr = top_ptr;
                    end else begin
                        ptr_nxt = ptr_dn;
                        cnt_nxt = rasCount - 5'd1;
                    end
                end else if (push) begin
                    wr_en   = 1'b1;
                    wr_ptr  = ptr_up;
                    ptr_nxt = ptr_up;
                    cnt_nxt = 5'd1;
                end
            end else if (push) begin
                wr_en   = 1'b1;
                wr_ptr  = ptr_up;
                ptr_nxt = ptr_up;
                if (rasCount != 5'(RAS_DEPTH)) cnt_nxt = rasCount + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr  <= '0;
            rasCount <= 5'd0;
            rasErr   <= 1'b0;
        end else begin
            top_ptr  <= ptr_nxt;
            rasCount <= cnt_nxt;
            rasErr   <= err_nxt;
        end
    end

    // Storage is not reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) ras_mem[wr_ptr] <= pcInc;
    end
`else
    logic unused_push;
    assign unused_push = push;

    always_comb begin
        pc_nxt = PCOut;
        if (ldPC) begin
            case (selPC)
                2'b00:   pc_nxt = pcInc;
                2'b01:   pc_nxt = eabOut;
                default: pc_nxt = Bus;
            endcase
        end
    end

    assign rasCount = 5'd0;
    assign rasErr   = 1'b0;
`endif

endmodule
